imem_fetch_responder: RTL and testbench

- Instruction-memory responder on the fetch side of the pipeline: accepts fetch requests from the IF stage, returns one 32-bit instruction per request after a configurable latency.
- Handshakes are valid/ready.
- A flush input cancels the outstanding fetch when a branch redirects the PC.
- A write port preloads the program from the bench or a boot loader.

---
 rtl/imem_fetch_responder_if.sv | 28 ++
 rtl/imem_fetch_responder.sv | 95 +++++++++
 tb/tb_imem_fetch_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bus between the IF stage and the instruction memory responder:
// request and response valid/ready handshakes plus the preload write port.
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_error;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    // IF stage / bench side: issues fetches, consumes responses, preloads memory
    modport master (
        output req_valid, req_addr, req_flush, resp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_instr, resp_addr, resp_error
    );

    // Responder side
    modport slave (
        input  req_valid, req_addr, req_flush, resp_ready, wr_en, wr_addr, wr_data,
        output req_ready, resp_valid, resp_instr, resp_addr, resp_error
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: one fetch outstanding at a time, response
// returned LATENCY edges after acceptance, flushable on a taken branch.
// Misaligned or out-of-range fetches return NOP_INSTR with resp_error set.
module imem_fetch_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                   clock,
    input  logic                   reset,
    imem_fetch_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         cnt;
    logic [31:0]        lat_addr;
    logic               lat_err;
    logic [31:0]        mem [DEPTH_WORDS];
    logic               accept;
    logic               wr_in_range;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic               unused_wr_lsb;

    // Misaligned or beyond the end of the memory array.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    assign bus.req_ready = (state == IDLE) || (state == RESP && bus.resp_ready) || bus.req_flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rd_idx        = lat_addr[IDX_W+1:2];
    assign wr_idx        = bus.wr_addr[IDX_W+1:2];
    assign wr_in_range   = {2'b00, bus.wr_addr[31:2]} < 32'(DEPTH_WORDS);
    assign unused_wr_lsb = ^bus.wr_addr[1:0];

    // Preload write port; memory contents survive reset.
    always_ff @(posedge clock) begin
        if (bus.wr_en && wr_in_range) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    // Fetch FSM: acceptance (including flush-and-redirect) wins over every
    // other transition; a bare flush drops whatever is outstanding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            lat_addr       <= 32'd0;
            lat_err        <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_instr <= 32'd0;
            bus.resp_addr  <= 32'd0;
            bus.resp_error <= 1'b0;
        end else if (accept) begin
            lat_addr       <= bus.req_addr;
            lat_err        <= addr_err(bus.req_addr);
            cnt            <= 4'(LATENCY - 1);
            state          <= BUSY;
            bus.resp_valid <= 1'b0;
        end else if (bus.req_flush) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_addr  <= lat_addr;
                        bus.resp_instr <= lat_err ? NOP_INSTR : mem[rd_idx];
                        bus.resp_error <= lat_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: one instance at LATENCY=2 for the
// main scenarios, one at LATENCY=1 for the read/write collision case.
module tb_imem_fetch_responder;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    imem_fetch_responder_if bus();
    imem_fetch_responder_if bus2();

    imem_fetch_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .NOP_INSTR(32'h00000013)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    imem_fetch_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .NOP_INSTR(32'h00000013)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1; bus.wr_addr  = a; bus.wr_data  = d;
        bus2.wr_en  = 1'b1; bus2.wr_addr = a; bus2.wr_data = d;
        tick();
        bus.wr_en  = 1'b0;
        bus2.wr_en = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] instr,
                            input logic [31:0] addr, input logic err);
        chk({tag, ".valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, ".instr"}, bus.resp_instr, instr);
        chk({tag, ".addr"},  bus.resp_addr,  addr);
        chk({tag, ".err"},   32'(bus.resp_error), 32'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.req_valid = 0; bus.req_addr = 0; bus.req_flush = 0; bus.resp_ready = 1;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus2.req_valid = 0; bus2.req_addr = 0; bus2.req_flush = 0; bus2.resp_ready = 1;
        bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0;

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst.valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.instr", bus.resp_instr, 32'd0);
        chk("rst.addr",  bus.resp_addr,  32'd0);
        chk("rst.err",   32'(bus.resp_error), 32'd0);
        chk("rst.ready", 32'(bus.req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b1;

        // Preload program
        preload(32'h0,  32'h00500093);
        preload(32'h4,  32'h00a00113);
        preload(32'h8,  32'h00c00193);
        preload(32'hC,  32'hAAAA0001);
        preload(32'h40, 32'h01000213);

        // Fetch 0x0, then 0x4 back-to-back from RESP
        bus.req_valid = 1; bus.req_addr = 32'h0;
        tick();
        bus.req_valid = 0;
        chk("f0.lat1", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("f0.lat2", 32'(bus.resp_valid), 32'd0);
        tick();
        chk_resp("f0", 32'h00500093, 32'h0, 1'b0);
        bus.req_valid = 1; bus.req_addr = 32'h4;
        #1;
        chk("b2b.ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 0;
        chk("f4.lat1", 32'(bus.resp_valid), 32'd0);
        tick();
        tick();
        chk_resp("f4", 32'h00a00113, 32'h4, 1'b0);
        tick();
        chk("idle.valid", 32'(bus.resp_valid), 32'd0);
        chk("idle.hold",  bus.resp_instr, 32'h00a00113);

        // Backpressure on fetch 0x8
        bus.resp_ready = 0;
        bus.req_valid = 1; bus.req_addr = 32'h8;
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        bus.req_valid = 1; bus.req_addr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_resp("bp", 32'h00c00193, 32'h8, 1'b0);
            chk("bp.ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.resp_ready = 1;
        #1;
        chk("bp.release", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 0;
        chk("bp.busy", 32'(bus.resp_valid), 32'd0);
        tick();
        tick();
        chk_resp("bp.next", 32'h00a00113, 32'h4, 1'b0);
        tick();

        // Flush during BUSY redirects to 0x40
        bus.req_valid = 1; bus.req_addr = 32'h8;
        tick();
        bus.req_flush = 1; bus.req_addr = 32'h40;
        tick();
        bus.req_flush = 0; bus.req_valid = 0;
        chk("fl.v0", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("fl.v1", 32'(bus.resp_valid), 32'd0);
        tick();
        chk_resp("fl", 32'h01000213, 32'h40, 1'b0);
        tick();

        // Error fetches: misaligned, then one past the end back-to-back
        bus.req_valid = 1; bus.req_addr = 32'h6;
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        chk_resp("err.mis", 32'h00000013, 32'h6, 1'b1);
        bus.req_valid = 1; bus.req_addr = 32'h1000;
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        chk_resp("err.oor", 32'h00000013, 32'h1000, 1'b1);
        tick();

        // Read/write collision on the LATENCY=1 instance
        bus2.req_valid = 1; bus2.req_addr = 32'hC;
        tick();
        bus2.req_valid = 0;
        chk("col.lat", 32'(bus2.resp_valid), 32'd0);
        bus2.wr_en = 1; bus2.wr_addr = 32'hC; bus2.wr_data = 32'hBBBB0002;
        tick();
        bus2.wr_en = 0;
        chk("col.valid", 32'(bus2.resp_valid), 32'd1);
        chk("col.old",   bus2.resp_instr, 32'hAAAA0001);
        tick();
        bus2.req_valid = 1; bus2.req_addr = 32'hC;
        tick();
        bus2.req_valid = 0;
        tick();
        chk("col.new",  bus2.resp_instr, 32'hBBBB0002);
        chk("col.addr", bus2.resp_addr,  32'hC);

        // Asynchronous reset while BUSY
        bus.req_valid = 1; bus.req_addr = 32'h0;
        tick();
        bus.req_valid = 0;
        #2 reset = 1'b0;
        #1;
        chk("ar.valid", 32'(bus.resp_valid), 32'd0);
        chk("ar.instr", bus.resp_instr, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("ar.ready", 32'(bus.req_ready), 32'd1);
        chk("ar.noresp", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1; bus.req_addr = 32'h4;
        tick();
        bus.req_valid = 0;
        tick();
        tick();
        chk_resp("ar.mem", 32'h00a00113, 32'h4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
